// File: rtl/pipelined_control_unit.sv
// RV32 decode/control stage: instruction in, registered control word plus rd/rs1/rs2 out
// through an elastic valid/ready pipeline. Optional CU_ILLEGAL_TRAP_EN adds the illegal output.
module pipelined_control_unit #(
   parameter int CTRL_STAGES = 2,
   parameter int REG_ADDR_W  = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           instr,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  branch,
   output logic                  jump,
   output logic                  jump_reg,
   output logic                  mem_read,
   output logic                  mem_to_reg,
   output logic                  mem_write,
   output logic                  alu_src,
   output logic                  alu_a_pc,
   output logic                  reg_write,
   output logic [1:0]            alu_op,
   output logic [2:0]            imm_sel,
   output logic [REG_ADDR_W-1:0] rd,
   output logic [REG_ADDR_W-1:0] rs1,
   output logic [REG_ADDR_W-1:0] rs2,
`ifdef CU_ILLEGAL_TRAP_EN
   output logic                  illegal,
`endif
   output logic                  load_use_stall
);

   typedef struct packed {
      logic                  branch;
      logic                  jump;
      logic                  jump_reg;
      logic                  mem_read;
      logic                  mem_to_reg;
      logic                  mem_write;
      logic                  alu_src;
      logic                  alu_a_pc;
      logic                  reg_write;
      logic [1:0]            alu_op;
      logic [2:0]            imm_sel;
`ifdef CU_ILLEGAL_TRAP_EN
      logic                  illegal;
`endif
      logic [REG_ADDR_W-1:0] rd;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
   } ctrl_t;

   ctrl_t                  dec;
   ctrl_t                  stg [CTRL_STAGES];
   ctrl_t                  out_word;
   logic [CTRL_STAGES-1:0] v;
   logic [CTRL_STAGES-1:0] ld;
   logic                   is_load, uses_rs1, uses_rs2, known;
   logic                   hz_vld;
   logic [REG_ADDR_W-1:0]  hz_rd;
   logic                   accept;
   logic                   unused_instr;

   // Funct/immediate bits are consumed in EX, not here.
   assign unused_instr = ^instr;

   always_comb begin
      dec      = '0;
      is_load  = 1'b0;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      known    = 1'b1;
      case (instr[6:0])
         7'b0110011: begin
            dec.reg_write = 1'b1; dec.alu_op = 2'b10;
            uses_rs1 = 1'b1; uses_rs2 = 1'b1;
         end
         7'b0000011: begin
            dec.alu_src = 1'b1; dec.mem_read = 1'b1; dec.mem_to_reg = 1'b1;
            dec.reg_write = 1'b1; dec.alu_op = 2'b00; dec.imm_sel = 3'd0;
            is_load = 1'b1; uses_rs1 = 1'b1;
         end
         7'b0100011: begin
            dec.alu_src = 1'b1; dec.mem_write = 1'b1; dec.alu_op = 2'b00; dec.imm_sel = 3'd1;
            uses_rs1 = 1'b1; uses_rs2 = 1'b1;
         end
         7'b1100011: begin
            dec.branch = 1'b1; dec.alu_op = 2'b01; dec.imm_sel = 3'd2;
            uses_rs1 = 1'b1; uses_rs2 = 1'b1;
         end
         7'b0010011: begin
            dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 2'b11;
            uses_rs1 = 1'b1;
         end
         7'b1101111: begin
            dec.jump = 1'b1; dec.alu_src = 1'b1; dec.alu_a_pc = 1'b1; dec.reg_write = 1'b1;
            dec.alu_op = 2'b11; dec.imm_sel = 3'd4;
         end
         7'b1100111: begin
            dec.jump = 1'b1; dec.jump_reg = 1'b1; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
            dec.alu_op = 2'b11; uses_rs1 = 1'b1;
         end
         7'b0110111: begin
            dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 2'b11; dec.imm_sel = 3'd3;
         end
         7'b0010111: begin
            dec.alu_src = 1'b1; dec.alu_a_pc = 1'b1; dec.reg_write = 1'b1;
            dec.alu_op = 2'b00; dec.imm_sel = 3'd3;
         end
         default: known = 1'b0;
      endcase
`ifdef CU_ILLEGAL_TRAP_EN
      if (!known || instr[1:0] != 2'b11) begin
         dec         = '0;
         dec.illegal = 1'b1;
      end
`endif
      // Register indices pass through regardless of opcode; EX qualifies them.
      dec.rd  = instr[7 +: REG_ADDR_W];
      dec.rs1 = instr[15 +: REG_ADDR_W];
      dec.rs2 = instr[20 +: REG_ADDR_W];
   end

   // Handshake: a word moves on valid & ready in the same cycle. A stage loads when it is
   // empty or its successor loads, so ready ripples combinationally back from out_ready.
   always_comb begin
      ld = '0;
      ld[CTRL_STAGES-1] = !v[CTRL_STAGES-1] || out_ready;
      for (int i = CTRL_STAGES - 2; i >= 0; i--)
         ld[i] = !v[i] || ld[i+1];
   end

   assign load_use_stall = hz_vld && in_valid &&
                           ((uses_rs1 && dec.rs1 == hz_rd) || (uses_rs2 && dec.rs2 == hz_rd));
   assign in_ready = ld[0] && !load_use_stall && !flush;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         v      <= '0;
         hz_vld <= 1'b0;
      end else begin
         // The hazard window is exactly one cycle: the load's successor is the only victim.
         hz_vld <= accept && is_load && (dec.rd != '0);
         if (ld[0])
            v[0] <= accept;
         for (int i = 1; i < CTRL_STAGES; i++)
            if (ld[i])
               v[i] <= v[i-1];
      end
   end

   always_ff @(posedge clk) begin
      hz_rd <= dec.rd;
      if (ld[0])
         stg[0] <= dec;
      for (int i = 1; i < CTRL_STAGES; i++)
         if (ld[i])
            stg[i] <= stg[i-1];
   end

   assign out_valid = v[CTRL_STAGES-1];
   assign out_word  = out_valid ? stg[CTRL_STAGES-1] : '0;

   assign branch     = out_word.branch;
   assign jump       = out_word.jump;
   assign jump_reg   = out_word.jump_reg;
   assign mem_read   = out_word.mem_read;
   assign mem_to_reg = out_word.mem_to_reg;
   assign mem_write  = out_word.mem_write;
   assign alu_src    = out_word.alu_src;
   assign alu_a_pc   = out_word.alu_a_pc;
   assign reg_write  = out_word.reg_write;
   assign alu_op     = out_word.alu_op;
   assign imm_sel    = out_word.imm_sel;
   assign rd         = out_word.rd;
   assign rs1        = out_word.rs1;
   assign rs2        = out_word.rs2;
`ifdef CU_ILLEGAL_TRAP_EN
   assign illegal    = out_word.illegal;
`endif

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Testbench for pipelined_control_unit: directed steps plus random traffic checked against a
// transaction-level model (ordered queue of accepted instructions, decode table, hazard rule).
module tb_pipelined_control_unit;
   localparam int S = 2;
`ifdef CU_ILLEGAL_TRAP_EN
   localparam int WT = 30;
`else
   localparam int WT = 29;
`endif

   logic clk = 1'b0;
   logic rst, flush, in_valid, in_ready, out_valid, out_ready, load_use_stall;
   logic [31:0] instr;
   logic branch, jump, jump_reg, mem_read, mem_to_reg, mem_write, alu_src, alu_a_pc, reg_write;
   logic [1:0] alu_op;
   logic [2:0] imm_sel;
   logic [4:0] rd, rs1, rs2;
   logic [WT-1:0] obs_word;
`ifdef CU_ILLEGAL_TRAP_EN
   logic illegal;
   assign obs_word = {branch, jump, jump_reg, mem_read, mem_to_reg, mem_write, alu_src,
                      alu_a_pc, reg_write, alu_op, imm_sel, illegal, rd, rs1, rs2};
`else
   assign obs_word = {branch, jump, jump_reg, mem_read, mem_to_reg, mem_write, alu_src,
                      alu_a_pc, reg_write, alu_op, imm_sel, rd, rs1, rs2};
`endif

   always #5 clk = ~clk;

   pipelined_control_unit #(.CTRL_STAGES(S), .REG_ADDR_W(5)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
      .branch(branch), .jump(jump), .jump_reg(jump_reg), .mem_read(mem_read),
      .mem_to_reg(mem_to_reg), .mem_write(mem_write), .alu_src(alu_src), .alu_a_pc(alu_a_pc),
      .reg_write(reg_write), .alu_op(alu_op), .imm_sel(imm_sel), .rd(rd), .rs1(rs1), .rs2(rs2),
`ifdef CU_ILLEGAL_TRAP_EN
      .illegal(illegal),
`endif
      .load_use_stall(load_use_stall)
   );

   // Scoreboard state
   logic [31:0] exp_q[$];
   logic        m_hz_vld;
   logic [4:0]  m_hz_rd;
   int          checks = 0;
   int          passes = 0;
   int          pops   = 0;
   logic        last_stall, last_acc;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Decode table: {branch,jump,jump_reg,mem_read,mem_to_reg,mem_write,alu_src,alu_a_pc,reg_write}
   function automatic logic [WT-1:0] exp_word(input logic [31:0] x);
      logic [8:0] f;
      logic [1:0] op;
      logic [2:0] im;
      logic       ok;
      f = 9'b0; op = 2'b00; im = 3'd0; ok = 1'b1;
      case (x[6:0])
         7'b0110011: begin f = 9'b000000001; op = 2'b10; end
         7'b0000011: begin f = 9'b000110101; op = 2'b00; end
         7'b0100011: begin f = 9'b000001100; op = 2'b00; im = 3'd1; end
         7'b1100011: begin f = 9'b100000000; op = 2'b01; im = 3'd2; end
         7'b0010011: begin f = 9'b000000101; op = 2'b11; end
         7'b1101111: begin f = 9'b010000111; op = 2'b11; im = 3'd4; end
         7'b1100111: begin f = 9'b011000101; op = 2'b11; end
         7'b0110111: begin f = 9'b000000101; op = 2'b11; im = 3'd3; end
         7'b0010111: begin f = 9'b000000111; op = 2'b00; im = 3'd3; end
         default:    ok = 1'b0;
      endcase
`ifdef CU_ILLEGAL_TRAP_EN
      return {f, op, im, !ok, x[11:7], x[19:15], x[24:20]};
`else
      return {f, op, im, x[11:7], x[19:15], x[24:20]};
`endif
   endfunction

   function automatic logic hazard(input logic [31:0] x, input logic [4:0] hrd);
      logic u1, u2;
      u1 = x[6:0] inside {7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011, 7'b1100111};
      u2 = x[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
      return (u1 && x[19:15] == hrd) || (u2 && x[24:20] == hrd);
   endfunction

   // One clock: check at the falling edge, then advance the model at the rising edge.
   task automatic cycle();
      logic stall_e, rdy_e, acc_e, ov, orr;
      @(negedge clk);
      stall_e = m_hz_vld && in_valid && hazard(instr, m_hz_rd);
      rdy_e   = ((exp_q.size() < S) || out_ready) && !stall_e && !flush;
      chk("load_use_stall", load_use_stall, stall_e);
      chk("in_ready", in_ready, rdy_e);
      if (out_valid) begin
         if (exp_q.size() == 0) chk("out_valid_with_nothing_in_flight", out_valid, 1'b0);
         else chk("out_word", obs_word, exp_word(exp_q[0]));
      end else begin
         chk("masked_out_word", obs_word, '0);
      end
      acc_e      = in_valid && rdy_e;
      last_stall = load_use_stall;
      last_acc   = in_valid && in_ready;
      ov  = out_valid;
      orr = out_ready;
      @(posedge clk);
      if (ov && orr && exp_q.size() > 0) begin
         void'(exp_q.pop_front());
         pops++;
      end
      if (rst || flush) begin
         exp_q.delete();
         m_hz_vld = 1'b0;
      end else begin
         m_hz_vld = acc_e && (instr[6:0] == 7'b0000011) && (instr[11:7] != 5'd0);
         m_hz_rd  = instr[11:7];
         if (acc_e) exp_q.push_back(instr);
      end
      #1;
   endtask

   function automatic logic [31:0] rnd_instr();
      logic [31:0] x;
      logic [6:0]  opcs [10];
      opcs = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011,
               7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0000000};
      x = $urandom;
      x[24:20] = 5'($urandom_range(0, 3));
      x[19:15] = 5'($urandom_range(0, 3));
      x[11:7]  = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 9) != 0) x[6:0] = opcs[$urandom_range(0, 9)];
      return x;
   endfunction

   initial begin
      int acc, guard;
      logic sw_seen;
      // Reset held for two cycles with a valid instruction presented
      rst = 1'b1; flush = 1'b0; in_valid = 1'b1; instr = 32'h002081B3; out_ready = 1'b1;
      exp_q.delete(); m_hz_vld = 1'b0; m_hz_rd = 5'd0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         chk("rst_out_valid", out_valid, 1'b0);
         chk("rst_outputs", obs_word, '0);
         chk("rst_stall", load_use_stall, 1'b0);
         chk("rst_in_ready", in_ready, 1'b1);
      end
      rst = 1'b0; in_valid = 1'b0;
      repeat (3) cycle();

      // add x3,x1,x2: visible S cycles after acceptance
      in_valid = 1'b1; instr = 32'h002081B3;
      cycle();
      in_valid = 1'b0;
      cycle();
      chk("add_out_valid", out_valid, 1'b1);
      chk("add_reg_write", reg_write, 1'b1);
      chk("add_alu_op", alu_op, 2'b10);
      chk("add_rd", rd, 5'd3);
      chk("add_rs1", rs1, 5'd1);
      chk("add_rs2", rs2, 5'd2);
      repeat (3) cycle();

      // lw x5 then add x6,x5,x1: one bubble
      in_valid = 1'b1; instr = 32'h0000A283;
      cycle();
      instr = 32'h00128333;
      cycle();
      chk("lu_stall_asserted", last_stall, 1'b1);
      chk("lu_no_accept", last_acc, 1'b0);
      cycle();
      chk("lu_stall_released", last_stall, 1'b0);
      chk("lu_accept_after_bubble", last_acc, 1'b1);
      in_valid = 1'b0;
      repeat (4) cycle();

      // Reset during a load-use stall releases it
      in_valid = 1'b1; instr = 32'h0000A283;
      cycle();
      instr = 32'h00128333; rst = 1'b1;
      cycle();
      rst = 1'b0;
      cycle();
      chk("rst_mid_stall_accept", last_acc, 1'b1);
      in_valid = 1'b0;
      repeat (4) cycle();

      // sw stream with back-pressure
      pops = 0; acc = 0; guard = 0; sw_seen = 1'b0;
      in_valid = 1'b1; instr = 32'h00512223; out_ready = 1'b0;
      while (acc < 4 && guard < 50) begin
         if (guard == 3) out_ready = 1'b1;
         cycle();
         if (guard == 2) chk("sw_full_in_ready", last_acc, 1'b0);
         if (last_acc) acc++;
         if (out_valid && !sw_seen) begin
            sw_seen = 1'b1;
            chk("sw_mem_write", mem_write, 1'b1);
            chk("sw_imm_sel", imm_sel, 3'd1);
         end
         guard++;
      end
      chk("sw_accepted", acc, 4);
      in_valid = 1'b0;
      repeat (5) cycle();
      chk("sw_delivered", pops, 4);

      // flush with two words in flight
      out_ready = 1'b0; in_valid = 1'b1; instr = 32'h002081B3;
      cycle(); cycle();
      flush = 1'b1; instr = 32'h00100093;
      cycle();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      chk("flush_out_valid", out_valid, 1'b0);
      repeat (4) cycle();

      // all-ones instruction
      in_valid = 1'b1; instr = 32'hFFFFFFFF;
      cycle();
      in_valid = 1'b0;
      cycle();
      chk("ffff_out_valid", out_valid, 1'b1);
      chk("ffff_controls", {branch, jump, jump_reg, mem_read, mem_to_reg, mem_write, alu_src,
                            alu_a_pc, reg_write, alu_op, imm_sel}, 14'd0);
`ifdef CU_ILLEGAL_TRAP_EN
      chk("ffff_illegal", illegal, 1'b1);
`endif
      repeat (3) cycle();

      // random traffic
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 24) == 0);
         instr     = rnd_instr();
         cycle();
      end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (S + 3) cycle();
      chk("drained_out_valid", out_valid, 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
